// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multi-cycle sequencer for the 16-bit CPU.
//
// Fetches one instruction at a time over a req/ack memory port, decodes it and
// steps through EXECUTE / MEM / WRITEBACK as the opcode requires, driving the
// ALU decoder, register file, PC and memory controls for each phase. Counts
// retired instructions and parks in HALT on a HALT opcode, an illegal encoding
// or a memory request that goes unacknowledged for MEM_TIMEOUT cycles.
//
// Ports
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   start         leave IDLE and start fetching (looked at in IDLE only)
//   instr         instruction register contents, valid from DECODE on
//   alu_zero      ALU result is zero (beq condition)
//   mem_ack       memory finished the current request this cycle
//   ir_we, pc_we, pc_src                    instruction register / PC controls
//   alu_op, alu_func, alu_src_imm           ALU decoder controls
//   reg_we, reg_dst_rd, wb_src_mem          register file write controls
//   mem_req, mem_we, mem_addr_alu           memory port controls
//   halted        in HALT state
//   illegal       sticky: illegal opcode/func caused the halt
//   bus_err       sticky: memory timeout caused the halt
//   instr_count   retired instructions, wraps modulo 2^CNT_W
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      instr,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic [2:0]       alu_op,
  output logic [3:0]       alu_func,
  output logic             alu_src_imm,
  output logic             reg_we,
  output logic             reg_dst_rd,
  output logic             wb_src_mem,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_alu,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  // The counter only has to reach MEM_TIMEOUT-1; the cycle that would take it
  // to MEM_TIMEOUT is the one that moves the FSM into HALT instead.
  localparam int             TO_W    = $clog2(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          state, state_next;
  logic [TO_W-1:0] tcnt, tcnt_next;
  logic            retire, set_illegal, set_bus_err, timeout_hit;

  // Instruction fields.
  logic [2:0] op;
  logic [3:0] func;
  assign op   = instr[15:13];
  assign func = instr[3:0];

  // Register specifiers and the immediate go straight to the datapath.
  logic unused_fields;
  assign unused_fields = ^instr[12:4];

  logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_halt, is_illegal;
  assign is_rtype   = (op == 3'b000);
  assign is_addi    = (op == 3'b001);
  assign is_lw      = (op == 3'b010);
  assign is_sw      = (op == 3'b011);
  assign is_beq     = (op == 3'b100);
  assign is_halt    = (op == 3'b111);
  assign is_illegal = (op == 3'b101) || (op == 3'b110) ||
                      (is_rtype && !(func inside {4'b0000, 4'b0001, 4'b0100,
                                                  4'b0101, 4'b0110, 4'b0111}));

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    retire       = 1'b0;
    set_illegal  = 1'b0;
    set_bus_err  = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    alu_op       = 3'b000;
    alu_func     = 4'b0000;
    alu_src_imm  = 1'b0;
    reg_we       = 1'b0;
    reg_dst_rd   = 1'b0;
    wb_src_mem   = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_alu = 1'b0;
    halted       = 1'b0;

    unique case (state)
      S_IDLE: if (start) state_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_illegal) begin
          set_illegal = 1'b1;
          state_next  = S_HALT;
        end else if (is_halt) begin
          state_next  = S_HALT;
        end else begin
          state_next  = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_rtype) begin
          alu_func   = func;
          state_next = S_WB;
        end else if (is_beq) begin
          alu_func   = 4'b0001;
          pc_we      = alu_zero;
          pc_src     = alu_zero;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          // addi / lw / sw: address or sum = rs + sext(imm7)
          alu_op      = 3'b001;
          alu_src_imm = 1'b1;
          state_next  = is_addi ? S_WB : S_MEM;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_alu = 1'b1;
        mem_we       = is_sw;
        alu_op       = 3'b001;
        alu_src_imm  = 1'b1;
        if (mem_ack) begin
          retire     = is_sw;
          state_next = is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst_rd = is_rtype;
        wb_src_mem = is_lw;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_next = S_HALT;
    endcase

    // A request only ever waits in its own state, so counting consecutive
    // unacknowledged request cycles is enough to detect a hung bus.
    timeout_hit = mem_req && !mem_ack && (tcnt == TO_LAST);
    if (timeout_hit) begin
      state_next  = S_HALT;
      set_bus_err = 1'b1;
    end
    tcnt_next = (mem_req && !mem_ack && !timeout_hit) ? tcnt + TO_W'(1) : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_next;
      tcnt  <= tcnt_next;
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl -- self-checking bench for multicycle_ctrl.
//
// Small parameters (MEM_TIMEOUT=4, CNT_W=4) make the bus timeout and the
// counter wrap cheap to reach. Each instruction is described at transaction
// level (encoding, fetch ack delay, MEM ack delay, alu_zero); run_instr turns
// that into the expected output vector of every cycle, and a compare process
// checks the DUT against that expectation on each falling edge.
module tb_multicycle_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   instr = '0;
  logic          alu_zero = 1'b0;
  logic          mem_ack = 1'b0;
  logic          ir_we, pc_we, pc_src, alu_src_imm, reg_we, reg_dst_rd;
  logic          wb_src_mem, mem_req, mem_we, mem_addr_alu, halted, illegal, bus_err;
  logic [2:0]    alu_op;
  logic [3:0]    alu_func;
  logic [CW-1:0] instr_count;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
    .alu_zero(alu_zero), .mem_ack(mem_ack),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_op(alu_op), .alu_func(alu_func), .alu_src_imm(alu_src_imm),
    .reg_we(reg_we), .reg_dst_rd(reg_dst_rd), .wb_src_mem(wb_src_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_alu(mem_addr_alu),
    .halted(halted), .illegal(illegal), .bus_err(bus_err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ir_we, pc_we, pc_src;
    logic [2:0]    alu_op;
    logic [3:0]    alu_func;
    logic          alu_src_imm, reg_we, reg_dst_rd, wb_src_mem;
    logic          mem_req, mem_we, mem_addr_alu;
    logic          halted, illegal, bus_err;
    logic [CW-1:0] count;
  } outs_t;

  outs_t act;
  assign act = {ir_we, pc_we, pc_src, alu_op, alu_func, alu_src_imm, reg_we,
                reg_dst_rd, wb_src_mem, mem_req, mem_we, mem_addr_alu,
                halted, illegal, bus_err, instr_count};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input outs_t a, input outs_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
    end
  endtask

  task automatic check_val(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, a, e, $time);
    end
  endtask

  // Reference model state.
  int    cnt = 0;
  bit    ill_f = 1'b0;
  bit    be_f = 1'b0;
  outs_t exp_v;
  bit    exp_valid = 1'b0;
  string exp_phase = "";
  int    branch_cycles = 0;

  always @(negedge clk) begin
    if (exp_valid) check({"cycle ", exp_phase}, act, exp_v);
    if (rst_n && pc_we && pc_src) branch_cycles++;
  end

  // Publish the expectation for the current cycle, then advance one clock.
  task automatic cycle(input string ph, input outs_t e);
    e.count   = CW'(cnt);
    e.illegal = ill_f;
    e.bus_err = be_f;
    exp_v     = e;
    exp_phase = ph;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic retire_one();
    cnt = (cnt + 1) % (1 << CW);
  endtask

  task automatic halt_cycles(input int n, input bit poke_start);
    outs_t e;
    start = poke_start;
    for (int i = 0; i < n; i++) begin
      mem_ack = (i % 2 == 1);
      e = '0;
      e.halted = 1'b1;
      cycle("halt", e);
    end
    start   = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    exp_valid = 1'b0;
    start     = 1'b0;
    mem_ack   = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    cnt   = 0;
    ill_f = 1'b0;
    be_f  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle("idle_start", '0);
    start = 1'b0;
  endtask

  // Expected behaviour of one whole instruction. A delay >= TO means the ack
  // never arrives in time and the bus timeout fires.
  task automatic run_instr(input logic [15:0] ins, input int fdel,
                           input int mdel, input bit zero);
    logic [2:0] op;
    logic [3:0] fn;
    outs_t      e;
    op       = ins[15:13];
    fn       = ins[3:0];
    instr    = ins;
    alu_zero = zero;
    for (int i = 0; i <= fdel; i++) begin
      if (i == TO) begin
        mem_ack = 1'b0;
        be_f    = 1'b1;
        halt_cycles(3, 1'b1);
        return;
      end
      mem_ack  = (i == fdel);
      e        = '0;
      e.mem_req = 1'b1;
      e.ir_we   = mem_ack;
      e.pc_we   = mem_ack;
      cycle("fetch", e);
    end
    mem_ack = 1'b0;
    cycle("decode", '0);
    if (op == 3'd5 || op == 3'd6 ||
        (op == 3'd0 && !(fn inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7}))) begin
      ill_f = 1'b1;
      halt_cycles(3, 1'b1);
      return;
    end
    if (op == 3'd7) begin
      halt_cycles(3, 1'b1);
      return;
    end
    e = '0;
    case (op)
      3'd0: e.alu_func = fn;
      3'd4: begin
        e.alu_func = 4'b0001;
        e.pc_we    = zero;
        e.pc_src   = zero;
      end
      default: begin
        e.alu_op      = 3'b001;
        e.alu_src_imm = 1'b1;
      end
    endcase
    cycle("execute", e);
    if (op == 3'd4) begin
      retire_one();
      return;
    end
    if (op == 3'd2 || op == 3'd3) begin
      for (int i = 0; i <= mdel; i++) begin
        if (i == TO) begin
          mem_ack = 1'b0;
          be_f    = 1'b1;
          halt_cycles(3, 1'b1);
          return;
        end
        mem_ack        = (i == mdel);
        e              = '0;
        e.mem_req      = 1'b1;
        e.mem_addr_alu = 1'b1;
        e.mem_we       = (op == 3'd3);
        e.alu_op       = 3'b001;
        e.alu_src_imm  = 1'b1;
        cycle("mem", e);
      end
      mem_ack = 1'b0;
      if (op == 3'd3) begin
        retire_one();
        return;
      end
    end
    e            = '0;
    e.reg_we     = 1'b1;
    e.reg_dst_rd = (op == 3'd0);
    e.wb_src_mem = (op == 3'd2);
    cycle("writeback", e);
    retire_one();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected < 200000", $time);
    $fatal(1);
  end

  initial begin
    outs_t e;
    int    b0;

    // Reset state, checked while rst_n is still low.
    #1;
    check("reset outputs", act, '0);
    do_reset();
    cycle("idle", '0);
    cycle("idle", '0);
    do_start();

    // add r3,r1,r2 with immediate ack.
    run_instr(16'h0530, 0, 0, 1'b0);
    check_val("count after add", int'(instr_count), 1);

    // lw with fetch ack after 1 wait, MEM ack after 3 waits.
    run_instr(16'h4085, 1, 3, 1'b0);
    run_instr(16'h6085, 0, 0, 1'b0);   // sw
    run_instr(16'h2085, 2, 0, 1'b0);   // addi
    check_val("count after lw/sw/addi", int'(instr_count), 4);

    b0 = branch_cycles;
    run_instr(16'h8083, 0, 0, 1'b1);   // beq taken
    check_val("beq taken branch cycles", branch_cycles - b0, 1);
    b0 = branch_cycles;
    run_instr(16'h8083, 0, 0, 1'b0);   // beq not taken
    check_val("beq not taken branch cycles", branch_cycles - b0, 0);
    check_val("count after beqs", int'(instr_count), 6);

    // Remaining legal R-type functions.
    run_instr(16'h0531, 0, 0, 1'b0);
    run_instr(16'h0534, 1, 0, 1'b0);
    run_instr(16'h0535, 0, 0, 1'b0);
    run_instr(16'h0536, 0, 0, 1'b0);
    run_instr(16'h0537, 3, 0, 1'b0);

    // Reset asserted in the middle of EXECUTE.
    instr   = 16'h0531;
    mem_ack = 1'b1;
    e = '0;
    e.mem_req = 1'b1;
    e.ir_we   = 1'b1;
    e.pc_we   = 1'b1;
    cycle("fetch", e);
    mem_ack = 1'b0;
    cycle("decode", '0);
    exp_valid = 1'b0;
    check_val("alu_func in execute before reset", int'(alu_func), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("outputs during mid-execute reset", act, '0);
    do_reset();
    check_val("count after mid-execute reset", int'(instr_count), 0);
    cycle("idle_after_reset", '0);

    // Counter wraps modulo 16.
    do_start();
    for (int i = 0; i < 17; i++) run_instr(16'h2085, 0, 0, 1'b0);
    check_val("count after 17 retires", int'(instr_count), 1);

    // Illegal R-type function.
    do_reset();
    do_start();
    run_instr(16'h0008, 0, 0, 1'b0);
    check_val("illegal func flag", int'(illegal), 1);
    check_val("illegal func halted", int'(halted), 1);
    check_val("illegal func count", int'(instr_count), 0);

    // Illegal opcode.
    do_reset();
    do_start();
    run_instr(16'hA000, 0, 0, 1'b0);
    check_val("illegal op flag", int'(illegal), 1);

    // HALT opcode: halted but not illegal.
    do_reset();
    do_start();
    run_instr(16'h0530, 0, 0, 1'b0);
    run_instr(16'hE000, 0, 0, 1'b0);
    check_val("halt op illegal flag", int'(illegal), 0);
    check_val("halt op count", int'(instr_count), 1);

    // Fetch never acknowledged.
    do_reset();
    do_start();
    run_instr(16'h0530, TO + 2, 0, 1'b0);
    check_val("fetch timeout bus_err", int'(bus_err), 1);
    check_val("fetch timeout mem_req", int'(mem_req), 0);

    // lw whose MEM access is never acknowledged.
    do_reset();
    do_start();
    run_instr(16'h4085, 0, TO + 1, 1'b0);
    check_val("mem timeout bus_err", int'(bus_err), 1);
    check_val("mem timeout halted", int'(halted), 1);

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
